// File: rtl/seq_control.sv
// Multi-cycle fetch / execute / memory sequencer for the RV32I core.
// Define SEQ_TRAP_EN to trap on illegal opcodes; otherwise they retire as NOPs.
module seq_control #(
  parameter int FETCH_WAIT = 0,
  parameter int RETIRE_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic                stall,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                en_iaddr,
  output logic                load_ir,
  output logic                en_dmem,
  output logic                reg_we,
  output logic                enable_pc_counter,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_LOAD_IR = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_MEM     = 3'd5;
  localparam logic [2:0] S_TRAP    = 3'd6;

  // A zero-width counter is not legal, so keep one bit when WAIT is never used.
  localparam int              CNT_W     = (FETCH_WAIT > 0) ? $clog2(FETCH_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(FETCH_WAIT);

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic is_plain_op(input logic [6:0] op);
    case (op)
      OP_ALU, OP_ALUI, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:                                                      return 1'b0;
    endcase
  endfunction

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             mem_is_load, mem_is_load_nxt;
  logic             ld_req;
  logic             done;
  logic             done_wr;

  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    mem_is_load_nxt = mem_is_load;
    ld_req          = 1'b0;
    done            = 1'b0;
    done_wr         = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_ADDR;
      S_ADDR: begin
        if (FETCH_WAIT > 0) begin
          state_nxt    = S_WAIT;
          wait_cnt_nxt = WAIT_LOAD;
        end else begin
          state_nxt = S_LOAD_IR;
        end
      end
      S_WAIT: begin
        if (wait_cnt > CNT_W'(1)) begin
          wait_cnt_nxt = wait_cnt - CNT_W'(1);
        end else begin
          wait_cnt_nxt = '0;
          state_nxt    = S_LOAD_IR;
        end
      end
      S_LOAD_IR: begin
        if (imem_ready) begin
          ld_req    = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_mem_op(opcode)) begin
          // Class is latched here so MEM ignores whatever the IR bus does later.
          mem_is_load_nxt = (opcode == OP_LOAD);
          state_nxt       = S_MEM;
        end else if (is_plain_op(opcode)) begin
          done      = 1'b1;
          done_wr   = (opcode != OP_BRANCH);
          state_nxt = S_ADDR;
        end else begin
`ifdef SEQ_TRAP_EN
          state_nxt = S_TRAP;
`else
          done      = 1'b1;
          state_nxt = S_ADDR;
`endif
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          done      = 1'b1;
          done_wr   = mem_is_load;
          state_nxt = S_ADDR;
        end
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stall freezes every register; the strobes below are masked separately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      mem_is_load <= 1'b0;
      retired     <= '0;
    end else if (!stall) begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_is_load <= mem_is_load_nxt;
      if (done) retired <= retired + RETIRE_W'(1);
    end
  end

  assign en_iaddr          = (state == S_ADDR) || (state == S_WAIT) || (state == S_LOAD_IR);
  assign en_dmem           = (state == S_MEM);
  assign load_ir           = ld_req & ~stall;
  assign enable_pc_counter = done & ~stall;
  assign reg_we            = done_wr & ~stall;

`ifdef SEQ_TRAP_EN
  assign halted = (state == S_TRAP);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_seq_control.sv
// Self-checking bench for seq_control: directed sequences plus randomized traffic
// against an instruction-level reference model (two parameterizations side by side).
`timescale 1ns/1ps
module tb_seq_control;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int M_IDLE = 0, M_FETCH = 1, M_WAIT = 2, M_IR = 3, M_EXEC = 4, M_MEM = 5, M_HALT = 6;

  typedef struct {
    int     ph;
    int     wl;
    longint ret;
    bit     ld;
  } mdl_t;

  typedef struct packed {
    bit iaddr;
    bit ldir;
    bit dmem;
    bit we;
    bit pc;
    bit halt;
  } exp_t;

  typedef struct {
    logic [6:0] op;
    bit st, im, dm;
    bit x_iaddr, x_ldir, x_we, x_pc;
    int x_ret;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [6:0] a_opcode, b_opcode;
  logic       a_stall, a_imem, a_dmem, b_stall, b_imem, b_dmem;
  logic       a_en_iaddr, a_load_ir, a_en_dmem, a_reg_we, a_pc, a_halted;
  logic       b_en_iaddr, b_load_ir, b_en_dmem, b_reg_we, b_pc, b_halted;
  logic [3:0]  a_retired;
  logic [31:0] b_retired;

  seq_control #(.FETCH_WAIT(0), .RETIRE_W(4)) u_a (
    .clk(clk), .rst(rst), .opcode(a_opcode), .stall(a_stall),
    .imem_ready(a_imem), .dmem_ready(a_dmem),
    .en_iaddr(a_en_iaddr), .load_ir(a_load_ir), .en_dmem(a_en_dmem),
    .reg_we(a_reg_we), .enable_pc_counter(a_pc), .halted(a_halted), .retired(a_retired)
  );

  seq_control #(.FETCH_WAIT(2), .RETIRE_W(32)) u_b (
    .clk(clk), .rst(rst), .opcode(b_opcode), .stall(b_stall),
    .imem_ready(b_imem), .dmem_ready(b_dmem),
    .en_iaddr(b_en_iaddr), .load_ir(b_load_ir), .en_dmem(b_en_dmem),
    .reg_we(b_reg_we), .enable_pc_counter(b_pc), .halted(b_halted), .retired(b_retired)
  );

  int checks = 0;
  int errors = 0;
  logic [6:0] legal_tbl [9];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (instruction lifecycle) ----------------
  function automatic bit is_ls(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic bit is_other_legal(input logic [6:0] op);
    return op inside {OP_ALU, OP_ALUI, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction

  function automatic mdl_t m_reset();
    mdl_t m;
    m.ph = M_IDLE; m.wl = 0; m.ret = 0; m.ld = 1'b0;
    return m;
  endfunction

  function automatic longint bump(input longint r, input int rw);
    return (r + 1) % (longint'(1) << rw);
  endfunction

  function automatic exp_t m_out(input mdl_t m, input logic [6:0] op, input bit st, input bit im, input bit dm);
    exp_t e;
    bit done, wr;
    e = '0; done = 1'b0; wr = 1'b0;
    e.iaddr = (m.ph == M_FETCH) || (m.ph == M_WAIT) || (m.ph == M_IR);
    e.dmem  = (m.ph == M_MEM);
    e.halt  = (m.ph == M_HALT);
    e.ldir  = (m.ph == M_IR) && im && !st;
    if (m.ph == M_EXEC && !is_ls(op)) begin
      if (is_other_legal(op)) begin
        done = 1'b1; wr = (op != OP_BRANCH);
      end else begin
`ifndef SEQ_TRAP_EN
        done = 1'b1;
`endif
      end
    end
    if (m.ph == M_MEM && dm) begin
      done = 1'b1; wr = m.ld;
    end
    e.pc = done && !st;
    e.we = wr && !st;
    return e;
  endfunction

  function automatic mdl_t m_next(input mdl_t m, input int fw, input int rw, input logic [6:0] op,
                                  input bit r, input bit st, input bit im, input bit dm);
    mdl_t n;
    n = m;
    if (!r) return m_reset();
    if (st) return n;
    case (m.ph)
      M_IDLE:  n.ph = M_FETCH;
      M_FETCH: if (fw > 0) begin n.ph = M_WAIT; n.wl = fw; end else n.ph = M_IR;
      M_WAIT:  begin n.wl = m.wl - 1; if (n.wl == 0) n.ph = M_IR; end
      M_IR:    if (im) n.ph = M_EXEC;
      M_EXEC: begin
        if (is_ls(op)) begin
          n.ph = M_MEM; n.ld = (op == OP_LOAD);
        end else if (is_other_legal(op)) begin
          n.ret = bump(m.ret, rw); n.ph = M_FETCH;
        end else begin
`ifdef SEQ_TRAP_EN
          n.ph = M_HALT;
`else
          n.ret = bump(m.ret, rw); n.ph = M_FETCH;
`endif
        end
      end
      M_MEM:   if (dm) begin n.ret = bump(m.ret, rw); n.ph = M_FETCH; end
      default: n = m;
    endcase
    return n;
  endfunction

  task automatic cmp_a(input exp_t e, input longint r);
    chk1("a_en_iaddr", a_en_iaddr, e.iaddr);
    chk1("a_load_ir", a_load_ir, e.ldir);
    chk1("a_en_dmem", a_en_dmem, e.dmem);
    chk1("a_reg_we", a_reg_we, e.we);
    chk1("a_pc", a_pc, e.pc);
    chk1("a_halted", a_halted, e.halt);
    chkw("a_retired", 32'(a_retired), 32'(r));
  endtask

  task automatic cmp_b(input exp_t e, input longint r);
    chk1("b_en_iaddr", b_en_iaddr, e.iaddr);
    chk1("b_load_ir", b_load_ir, e.ldir);
    chk1("b_en_dmem", b_en_dmem, e.dmem);
    chk1("b_reg_we", b_reg_we, e.we);
    chk1("b_pc", b_pc, e.pc);
    chk1("b_halted", b_halted, e.halt);
    chkw("b_retired", b_retired, 32'(r));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_opcode = 7'd0; a_stall = 1'b0; a_imem = 1'b1; a_dmem = 1'b1;
    b_opcode = 7'd0; b_stall = 1'b0; b_imem = 1'b1; b_dmem = 1'b1;
  endtask

  // Leaves the bench 1ns after the edge that sampled rst released: cycle 0, IDLE.
  task automatic reset_all();
    tick();
    rst = 1'b0;
    clear_inputs();
    tick();
    rst = 1'b1;
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] op;
    if ($urandom_range(0, 15) == 0) op = 7'($urandom);
    else op = legal_tbl[$urandom_range(0, 8)];
    return op;
  endfunction

  vec_t tv [10];
  mdl_t ma, mb;
  exp_t ea, eb;
  int   n_we, n_pc, pulses;
  bit   hit;

  initial begin
    legal_tbl = '{OP_LOAD, OP_STORE, OP_ALU, OP_ALUI, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    //            op       st im dm iaddr ldir we pc ret
    tv[0] = '{OP_ALUI, 0, 1, 1, 1, 0, 0, 0, 0};
    tv[1] = '{OP_ALUI, 0, 1, 1, 1, 1, 0, 0, 0};
    tv[2] = '{OP_ALUI, 0, 1, 1, 0, 0, 1, 1, 0};
    tv[3] = '{OP_ALUI, 0, 1, 1, 1, 0, 0, 0, 1};
    tv[4] = '{OP_ALUI, 0, 1, 1, 1, 1, 0, 0, 1};
    tv[5] = '{OP_ALUI, 0, 1, 1, 0, 0, 1, 1, 1};
    tv[6] = '{OP_ALUI, 0, 1, 1, 1, 0, 0, 0, 2};
    tv[7] = '{OP_ALUI, 0, 1, 1, 1, 1, 0, 0, 2};
    tv[8] = '{OP_ALUI, 0, 1, 1, 0, 0, 1, 1, 2};
    tv[9] = '{OP_ALUI, 0, 1, 1, 1, 0, 0, 0, 3};

    clear_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    tick();
    tick();
    cmp_a('0, 0);
    cmp_b('0, 0);

    // ---- three ALUI instructions, table driven, then wrap of the 4-bit counter
    reset_all();
    for (int k = 0; k < 10; k++) begin
      tick();
      a_opcode = tv[k].op; a_stall = tv[k].st; a_imem = tv[k].im; a_dmem = tv[k].dm;
      #1;
      chk1("t1_en_iaddr", a_en_iaddr, tv[k].x_iaddr);
      chk1("t1_load_ir", a_load_ir, tv[k].x_ldir);
      chk1("t1_reg_we", a_reg_we, tv[k].x_we);
      chk1("t1_pc", a_pc, tv[k].x_pc);
      chk1("t1_en_dmem", a_en_dmem, 1'b0);
      chkw("t1_retired", 32'(a_retired), 32'(tv[k].x_ret));
    end
    pulses = 0;
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      tick();
      #1;
      if (a_pc === 1'b1) begin
        pulses++;
        if (pulses == 13) begin
          chkw("wrap_pre", 32'(a_retired), 32'd15);
          hit = 1'b1;
        end
      end
    end
    if (!hit) begin
      errors++;
      $display("FAIL wrap_timeout got %0d pulses want 13", pulses);
    end else begin
      tick();
      #1;
      chkw("wrap_post", 32'(a_retired), 32'd0);
    end

    // ---- FETCH_WAIT=2 load with one imem and three dmem bubbles: 10 cycles
    reset_all();
    n_we = 0; n_pc = 0;
    b_opcode = OP_LOAD;
    for (int k = 1; k <= 11; k++) begin
      tick();
      b_imem = (k != 4);
      b_dmem = (k >= 10);
      #1;
      if (k <= 10) begin
        chk1("t2_en_iaddr", b_en_iaddr, k <= 5);
        chk1("t2_load_ir", b_load_ir, k == 5);
        chk1("t2_en_dmem", b_en_dmem, k >= 7);
        chk1("t2_reg_we", b_reg_we, k == 10);
        chk1("t2_pc", b_pc, k == 10);
        n_we += int'(b_reg_we); n_pc += int'(b_pc);
      end else begin
        chkw("t2_retired", b_retired, 32'd1);
        chk1("t2_refetch", b_en_iaddr, 1'b1);
      end
    end
    chkw("t2_we_count", 32'(n_we), 32'd1);
    chkw("t2_pc_count", 32'(n_pc), 32'd1);

    // ---- store then branch; opcode flips to LOAD during MEM and must be ignored
    reset_all();
    n_we = 0; n_pc = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      a_opcode = (k <= 3) ? OP_STORE : ((k == 4) ? OP_LOAD : OP_BRANCH);
      #1;
      chk1("t3_reg_we", a_reg_we, 1'b0);
      chk1("t3_pc", a_pc, (k == 4) || (k == 7));
      chk1("t3_en_dmem", a_en_dmem, k == 4);
      n_pc += int'(a_pc);
      if (k == 8) chkw("t3_retired", 32'(a_retired), 32'd2);
    end
    chkw("t3_pc_count", 32'(n_pc), 32'd2);

    // ---- stall in LOAD_IR for one cycle and in EXEC for five
    reset_all();
    a_opcode = OP_ALU;
    for (int k = 1; k <= 10; k++) begin
      tick();
      a_stall = (k == 2) || (k >= 4 && k <= 8);
      #1;
      chk1("t4_load_ir", a_load_ir, k == 3);
      chk1("t4_pc", a_pc, k == 9);
      chk1("t4_reg_we", a_reg_we, k == 9);
      chk1("t4_en_iaddr", a_en_iaddr, (k <= 3) || (k == 10));
      chkw("t4_retired", 32'(a_retired), (k == 10) ? 32'd1 : 32'd0);
    end

    // ---- illegal opcode 0 in EXEC
    reset_all();
    a_opcode = 7'd0;
`ifdef SEQ_TRAP_EN
    for (int k = 1; k <= 24; k++) begin
      tick();
      #1;
      chk1("t5_pc", a_pc, 1'b0);
      chk1("t5_reg_we", a_reg_we, 1'b0);
      chk1("t5_halted", a_halted, k >= 4);
      chkw("t5_retired", 32'(a_retired), 32'd0);
      if (k >= 4) chk1("t5_quiet", a_en_iaddr | a_load_ir | a_en_dmem, 1'b0);
    end
    #2 rst = 1'b0;
    #1;
    chk1("t5_reset_unhalts", a_halted, 1'b0);
`else
    for (int k = 1; k <= 4; k++) begin
      tick();
      #1;
      chk1("t5_pc", a_pc, k == 3);
      chk1("t5_reg_we", a_reg_we, 1'b0);
      chk1("t5_halted", a_halted, 1'b0);
      if (k == 4) chkw("t5_retired", 32'(a_retired), 32'd1);
    end
`endif

    // ---- asynchronous reset while stuck in MEM
    reset_all();
    b_dmem = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      b_opcode = (k <= 5) ? OP_ALU : OP_STORE;
      #1;
    end
    chk1("t6_in_mem", b_en_dmem, 1'b1);
    chkw("t6_retired_pre", b_retired, 32'd1);
    #2 rst = 1'b0;
    #1;
    cmp_b('0, 0);

    // ---- randomized traffic on both instances against the model
    reset_all();
    ma = m_reset();
    mb = m_reset();
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) != 0);
      a_opcode = rand_op();
      a_stall  = ($urandom_range(0, 4) == 0);
      a_imem   = ($urandom_range(0, 3) != 0);
      a_dmem   = ($urandom_range(0, 2) != 0);
      b_opcode = rand_op();
      b_stall  = ($urandom_range(0, 4) == 0);
      b_imem   = ($urandom_range(0, 3) != 0);
      b_dmem   = ($urandom_range(0, 2) != 0);
      #1;
      if (!rst) begin
        ma = m_reset();
        mb = m_reset();
      end
      ea = m_out(ma, a_opcode, a_stall, a_imem, a_dmem);
      eb = m_out(mb, b_opcode, b_stall, b_imem, b_dmem);
      cmp_a(ea, ma.ret);
      cmp_b(eb, mb.ret);
      ma = m_next(ma, 0, 4, a_opcode, rst, a_stall, a_imem, a_dmem);
      mb = m_next(mb, 2, 32, b_opcode, rst, b_stall, b_imem, b_dmem);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
